// File: rtl/kbd_axil_arbiter_if.sv
// AXI4-Lite bus between the keyboard arbiter (master) and the keyboard
// register-file subordinate (slave).
interface kbd_axil_arbiter_if #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                M_AXI_AWPROT;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;
  logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                M_AXI_ARPROT;
  logic                      M_AXI_ARVALID;
  logic                      M_AXI_ARREADY;
  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RVALID;
  logic                      M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/kbd_axil_arbiter.sv
// Two-requester round-robin AXI4-Lite master for the keyboard register file.
// One single-beat transaction in flight at a time; the response pulses back
// only to the requester that was granted.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate, accept one command from the granted requester
// WR_ADDR   | AW and W presented; each drops after its own handshake
// WR_RESP   | BREADY high, waiting for BVALID
// RD_ADDR   | ARVALID high, waiting for ARREADY
// RD_DATA   | RREADY high, waiting for RVALID
// DONE      | one-cycle rspN_valid pulse to the granted requester
module kbd_axil_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_we,
  input  logic [C_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_DATA_WIDTH-1:0]   req0_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] req0_wstrb,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_we,
  input  logic [C_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_DATA_WIDTH-1:0]   req1_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                      rsp0_valid,
  output logic                      rsp1_valid,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  kbd_axil_arbiter_if.master        m_axi
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                state;
  logic                      prio;
  logic                      cur_id;
  logic                      aw_done;
  logic                      w_done;
  logic                      gnt_any;
  logic                      gnt_sel;
  logic                      accept;
  logic                      sel_we;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_DATA_WIDTH-1:0]   sel_wdata;
  logic [C_DATA_WIDTH/8-1:0] sel_wstrb;
  logic                      aw_hs;
  logic                      w_hs;

  // Round-robin grant and command mux; ready is gated by reset so nothing
  // is accepted while the block is held in reset.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_sel = prio;
    else                          gnt_sel = req1_valid;
    accept     = (state == S_IDLE) && gnt_any && !ARESET;
    req0_ready = accept && !gnt_sel;
    req1_ready = accept && gnt_sel;
    sel_we     = gnt_sel ? req1_we    : req0_we;
    sel_addr   = gnt_sel ? req1_addr  : req0_addr;
    sel_wdata  = gnt_sel ? req1_wdata : req0_wdata;
    sel_wstrb  = gnt_sel ? req1_wstrb : req0_wstrb;
  end

  // Ready/response strobes follow the state register directly, so an async
  // reset clears them in the same cycle it is asserted.
  always_comb begin
    aw_hs               = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
    w_hs                = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;
    m_axi.M_AXI_BREADY  = (state == S_WR_RESP);
    m_axi.M_AXI_RREADY  = (state == S_RD_DATA);
    m_axi.M_AXI_AWPROT  = 3'b000;
    m_axi.M_AXI_ARPROT  = 3'b000;
    rsp0_valid          = (state == S_DONE) && !cur_id;
    rsp1_valid          = (state == S_DONE) && cur_id;
  end

  // Transaction sequencer: latch command on accept, drive AXI channels,
  // capture the response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state               <= S_IDLE;
      prio                <= 1'b0;
      cur_id              <= 1'b0;
      aw_done             <= 1'b0;
      w_done              <= 1'b0;
      rsp_rdata           <= '0;
      rsp_resp            <= 2'b00;
      m_axi.M_AXI_AWADDR  <= '0;
      m_axi.M_AXI_AWVALID <= 1'b0;
      m_axi.M_AXI_WDATA   <= '0;
      m_axi.M_AXI_WSTRB   <= '0;
      m_axi.M_AXI_WVALID  <= 1'b0;
      m_axi.M_AXI_ARADDR  <= '0;
      m_axi.M_AXI_ARVALID <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_id <= gnt_sel;
            prio   <= ~gnt_sel;
            if (sel_we) begin
              m_axi.M_AXI_AWADDR  <= {sel_addr[C_ADDR_WIDTH-1:2], 2'b00};
              m_axi.M_AXI_WDATA   <= sel_wdata;
              m_axi.M_AXI_WSTRB   <= sel_wstrb;
              m_axi.M_AXI_AWVALID <= 1'b1;
              m_axi.M_AXI_WVALID  <= 1'b1;
              aw_done             <= 1'b0;
              w_done              <= 1'b0;
              state               <= S_WR_ADDR;
            end else begin
              m_axi.M_AXI_ARADDR  <= {sel_addr[C_ADDR_WIDTH-1:2], 2'b00};
              m_axi.M_AXI_ARVALID <= 1'b1;
              state               <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (aw_hs) begin
            m_axi.M_AXI_AWVALID <= 1'b0;
            aw_done             <= 1'b1;
          end
          if (w_hs) begin
            m_axi.M_AXI_WVALID <= 1'b0;
            w_done             <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            rsp_resp <= m_axi.M_AXI_BRESP;
            state    <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            m_axi.M_AXI_ARVALID <= 1'b0;
            state               <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            rsp_rdata <= m_axi.M_AXI_RDATA;
            rsp_resp  <= m_axi.M_AXI_RRESP;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_axil_arbiter.sv
// Bench for kbd_axil_arbiter: directed commands, expected responses queued
// into a scoreboard, a monitor pops them on each rspN_valid pulse, and a
// behavioural 4x32 register-file subordinate with programmable wait states.
module tb_kbd_axil_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  logic ACLK = 1'b0;
  logic ARESET;
  logic req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr, req0_wstrb;
  logic [31:0] req0_wdata;
  logic req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr, req1_wstrb;
  logic [31:0] req1_wdata;
  logic rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;

  kbd_axil_arbiter_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) axi ();

  kbd_axil_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(axi)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  exp_t        sb[$];
  bit          grant_log[$];
  int          total = 0;
  int          bad = 0;
  int unsigned last_acc_cyc = 0;
  logic [31:0] regs[4];
  int          aw_delay = 0;
  int          r_delay = 0;
  logic [1:0]  force_rresp = 2'b00;
  int          aw_hi = 0;
  int          w_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input bit we, input logic [3:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
    return c;
  endfunction

  task automatic expect_rsp(input bit id, input logic [31:0] rd, input logic [1:0] resp, input int lat);
    exp_t e;
    e.id = id; e.rdata = rd; e.resp = resp; e.lat = lat;
    sb.push_back(e);
  endtask

  // Subordinate model: decisions are made at negedge, handshakes complete
  // at the following posedge.
  task automatic sub_model();
    bit hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
    bit have_aw = 0, have_w = 0, have_ar = 0;
    logic [3:0] a_aw = 0, a_ar = 0, s_w = 0;
    logic [31:0] d_w = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0; axi.M_AXI_ARREADY = 0;
        axi.M_AXI_BVALID = 0; axi.M_AXI_RVALID = 0;
        for (int i = 0; i < 4; i++) regs[i] = 32'h0;
        continue;
      end
      if (hs_aw) have_aw = 1;
      if (hs_w) have_w = 1;
      if (hs_ar) have_ar = 1;
      if (hs_b) axi.M_AXI_BVALID = 0;
      if (hs_r) axi.M_AXI_RVALID = 0;
      if (have_aw && have_w) begin
        for (int b = 0; b < 4; b++)
          if (s_w[b]) regs[a_aw[3:2]][8*b +: 8] = d_w[8*b +: 8];
        have_aw = 0; have_w = 0;
        axi.M_AXI_BVALID = 1; axi.M_AXI_BRESP = 2'b00;
      end
      if (axi.M_AXI_AWVALID) begin aw_hi++; aw_cnt++; end else aw_cnt = 0;
      axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt > aw_delay);
      if (axi.M_AXI_AWREADY) a_aw = axi.M_AXI_AWADDR;
      if (axi.M_AXI_WVALID) begin w_hi++; w_cnt++; end else w_cnt = 0;
      axi.M_AXI_WREADY = axi.M_AXI_WVALID && (w_cnt > 0);
      if (axi.M_AXI_WREADY) begin d_w = axi.M_AXI_WDATA; s_w = axi.M_AXI_WSTRB; end
      if (axi.M_AXI_ARVALID) ar_cnt++; else ar_cnt = 0;
      axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && (ar_cnt > 0);
      if (axi.M_AXI_ARREADY) a_ar = axi.M_AXI_ARADDR;
      if (have_ar && !axi.M_AXI_RVALID) begin
        r_cnt++;
        if (r_cnt > r_delay) begin
          axi.M_AXI_RVALID = 1;
          axi.M_AXI_RDATA  = regs[a_ar[3:2]];
          axi.M_AXI_RRESP  = force_rresp;
          have_ar = 0; r_cnt = 0;
        end
      end
      hs_aw = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
      hs_w  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
      hs_ar = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
      hs_b  = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
      hs_r  = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESET && (rsp0_valid || rsp1_valid)) begin
        chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'h0);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got rsp0=%0d rsp1=%0d expected none", rsp0_valid, rsp1_valid);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          if (e.lat >= 0) chk("rsp_latency", 32'(cyc - last_acc_cyc), 32'(e.lat));
        end
      end
    end
  endtask

  // Present commands (called at a negedge) and hold each until accepted.
  task automatic issue(input bit v0, input cmd_t c0, input bit v1, input cmd_t c1);
    bit p0 = v0, p1 = v1;
    int t = 0;
    req0_we = c0.we; req0_addr = c0.addr; req0_wdata = c0.wdata; req0_wstrb = c0.wstrb;
    req1_we = c1.we; req1_addr = c1.addr; req1_wdata = c1.wdata; req1_wstrb = c1.wstrb;
    req0_valid = v0; req1_valid = v1;
    while ((p0 || p1) && t < 100) begin
      #1;
      if (req0_ready && req1_ready) chk("ready_onehot", 32'h1, 32'h0);
      if (req0_ready) begin grant_log.push_back(1'b0); last_acc_cyc = cyc; p0 = 0; end
      else if (req1_ready) begin grant_log.push_back(1'b1); last_acc_cyc = cyc; p1 = 0; end
      @(negedge ACLK);
      t++;
      if (!p0) req0_valid = 0;
      if (!p1) req1_valid = 0;
    end
    if (p0 || p1) begin
      total++; bad++;
      $display("FAIL issue_timeout: got pending0=%0d pending1=%0d expected both accepted", p0, p1);
      req0_valid = 0; req1_valid = 0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 100) begin @(negedge ACLK); t++; end
    chk("drain", 32'(sb.size()), 32'h0);
    @(negedge ACLK);
  endtask

  task automatic check_grants(input string name, input bit g0, input bit g1);
    chk({name, "_count"}, 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk({name, "_first"}, 32'(grant_log[0]), 32'(g0));
      chk({name, "_second"}, 32'(grant_log[1]), 32'(g1));
    end
  endtask

  cmd_t nc;
  int   a0, wc0, t;

  initial begin
    nc = mk(0, 4'h0, 32'h0, 4'h0);
    ARESET = 1;
    req0_valid = 1; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_wstrb = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_wstrb = 0;
    axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0; axi.M_AXI_ARREADY = 0;
    axi.M_AXI_BVALID = 0; axi.M_AXI_BRESP = 0;
    axi.M_AXI_RVALID = 0; axi.M_AXI_RDATA = 0; axi.M_AXI_RRESP = 0;
    fork
      sub_model();
      monitor();
    join_none
    repeat (3) @(negedge ACLK);

    chk("rst_awvalid", 32'(axi.M_AXI_AWVALID), 0);
    chk("rst_wvalid", 32'(axi.M_AXI_WVALID), 0);
    chk("rst_arvalid", 32'(axi.M_AXI_ARVALID), 0);
    chk("rst_bready", 32'(axi.M_AXI_BREADY), 0);
    chk("rst_rready", 32'(axi.M_AXI_RREADY), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", 32'(rsp_resp), 0);
    chk("rst_awaddr", 32'(axi.M_AXI_AWADDR), 0);
    chk("rst_araddr", 32'(axi.M_AXI_ARADDR), 0);
    chk("rst_wdata", axi.M_AXI_WDATA, 0);
    chk("rst_wstrb", 32'(axi.M_AXI_WSTRB), 0);
    chk("rst_prot", 32'({axi.M_AXI_AWPROT, axi.M_AXI_ARPROT}), 0);
    req0_valid = 0;
    ARESET = 0;
    @(negedge ACLK);

    // Single zero-wait write: AW/W in cycle 1, rsp0 in cycle 3.
    expect_rsp(0, 32'h0, 2'b00, 3);
    issue(1, mk(1, 4'h4, 32'h2, 4'hF), 0, nc);
    chk("t1_awvalid", 32'(axi.M_AXI_AWVALID), 1);
    chk("t1_wvalid", 32'(axi.M_AXI_WVALID), 1);
    chk("t1_awaddr", 32'(axi.M_AXI_AWADDR), 32'h4);
    chk("t1_wdata", axi.M_AXI_WDATA, 32'h2);
    chk("t1_wstrb", 32'(axi.M_AXI_WSTRB), 32'hF);
    drain();

    // Fill all four words, then read them back through req1.
    for (int i = 0; i < 4; i++) begin
      expect_rsp(0, 32'h0, 2'b00, -1);
      issue(1, mk(1, 4'(i * 4), 32'(i + 1), 4'hF), 0, nc);
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      expect_rsp(1, 32'(i + 1), 2'b00, (i == 0) ? 3 : -1);
      issue(0, nc, 1, mk(0, 4'(i * 4), 32'h0, 4'h0));
      drain();
    end

    // Unaligned address and partial strobes; rsp_rdata holds last read (4).
    expect_rsp(0, 32'h4, 2'b00, -1);
    issue(1, mk(1, 4'h2, 32'hAABBCCDD, 4'h3), 0, nc);
    chk("align_awaddr", 32'(axi.M_AXI_AWADDR), 32'h0);
    drain();
    expect_rsp(1, 32'h0000CCDD, 2'b00, -1);
    issue(0, nc, 1, mk(0, 4'h0, 32'h0, 4'h0));
    drain();

    // Contention after a req1 grant: pointer at 0 -> order 0,1.
    grant_log.delete();
    expect_rsp(0, 32'h0000CCDD, 2'b00, -1);
    expect_rsp(1, 32'h4, 2'b00, -1);
    issue(1, mk(1, 4'h8, 32'h33, 4'hF), 1, mk(0, 4'hC, 32'h0, 4'h0));
    drain();
    check_grants("pair1", 0, 1);

    // req0 alone moves the pointer to 1; next contention -> order 1,0.
    expect_rsp(0, 32'h33, 2'b00, -1);
    issue(1, mk(0, 4'h8, 32'h0, 4'h0), 0, nc);
    drain();
    grant_log.delete();
    expect_rsp(1, 32'h33, 2'b00, -1);
    expect_rsp(0, 32'h33, 2'b00, -1);
    issue(1, mk(1, 4'hC, 32'h44, 4'hF), 1, mk(0, 4'h8, 32'h0, 4'h0));
    drain();
    check_grants("pair2", 1, 0);

    // AWREADY three cycles late, WREADY immediate.
    aw_delay = 3;
    a0 = aw_hi; wc0 = w_hi;
    expect_rsp(0, 32'h33, 2'b00, 6);
    issue(1, mk(1, 4'h4, 32'h55, 4'hF), 0, nc);
    drain();
    chk("awdly_awvalid_cycles", 32'(aw_hi - a0), 32'd4);
    chk("awdly_wvalid_cycles", 32'(w_hi - wc0), 32'd1);
    aw_delay = 0;

    // SLVERR passthrough, then a normal request.
    force_rresp = 2'b10;
    expect_rsp(1, 32'h33, 2'b10, -1);
    issue(0, nc, 1, mk(0, 4'h8, 32'h0, 4'h0));
    drain();
    force_rresp = 2'b00;
    expect_rsp(0, 32'h55, 2'b00, 3);
    issue(1, mk(0, 4'h4, 32'h0, 4'h0), 0, nc);
    drain();

    // Reset while stalled in RD_DATA; no response expected for it.
    r_delay = 6;
    issue(1, mk(0, 4'hC, 32'h0, 4'h0), 0, nc);
    t = 0;
    while (!axi.M_AXI_RREADY && t < 20) begin @(negedge ACLK); t++; end
    chk("mid_rst_in_rd_data", 32'(axi.M_AXI_RREADY), 1);
    ARESET = 1;
    #1;
    chk("mid_rst_rready", 32'(axi.M_AXI_RREADY), 0);
    chk("mid_rst_arvalid", 32'(axi.M_AXI_ARVALID), 0);
    chk("mid_rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    r_delay = 0;
    @(negedge ACLK);
    expect_rsp(1, 32'h0, 2'b00, 3);
    issue(0, nc, 1, mk(0, 4'hC, 32'h0, 4'h0));
    drain();

    repeat (5) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
